// File: rtl/lc3_decode.sv
// ----------------------------------------------------------------------------
// lc3_decode
//
// Decode pipeline stage of the LC-3 datapath. On every rising clock edge
// where enable_decode is high, the fetched instruction word and its PC+1 are
// registered. The Execute, Writeback and memory-access control bundles are
// registered on the same edge. While enable_decode is low every output holds
// its value, which stalls the downstream stages.
//
// Ports:
//   clock          in   1   rising-edge clock
//   reset          in   1   asynchronous, active-high reset (clears outputs)
//   enable_decode  in   1   capture strobe, sampled at posedge
//   dout           in  16   instruction word from instruction memory
//   npc_in         in  16   PC+1 of the instruction on dout
//   IR             out 16   registered instruction
//   npc_out        out 16   registered npc_in
//   E_Control      out  6   {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_Control      out  2   writeback source: 00 ALU, 01 LEA address, 10 memory
//   Mem_Control    out  1   indirect memory access (LDI/STI)
//   illegal_op     out  1   registered unsupported-opcode flag
// ----------------------------------------------------------------------------
module lc3_decode (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
    output logic        illegal_op
);

    // Opcode encodings
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // Execute control patterns {alu[1:0], pcsel1[1:0], pcsel2, op2sel}
    localparam logic [5:0] E_PCREL9 = 6'b000110;  // NPC + offset9
    localparam logic [5:0] E_BASE6  = 6'b001000;  // BaseR + offset6
    localparam logic [5:0] E_BASE0  = 6'b001100;  // BaseR + 0 (JMP)
    localparam logic [5:0] E_NOT    = 6'b100000;

    // Writeback source selections
    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_PC  = 2'b01;
    localparam logic [1:0] W_MEM = 2'b10;

    logic [3:0] opcode;
    logic       reg_operand;
    logic [5:0] e_next;
    logic [1:0] w_next;
    logic       m_next;
    logic       ill_next;

    assign opcode = dout[15:12];

    // dout[5] is the immediate flag for ADD/AND; op2select picks the
    // register operand when that flag is clear.
    assign reg_operand = ~dout[5];

    // Decode straight from the incoming word so the control bundle is
    // registered on the same edge as IR and stays aligned with it.
    always_comb begin
        e_next   = 6'b000000;
        w_next   = W_ALU;
        m_next   = 1'b0;
        ill_next = 1'b0;
        case (opcode)
            OP_ADD: e_next = {5'b00000, reg_operand};
            OP_AND: e_next = {5'b01000, reg_operand};
            OP_NOT: e_next = E_NOT;
            OP_BR,
            OP_ST:  e_next = E_PCREL9;
            OP_LD: begin
                e_next = E_PCREL9;
                w_next = W_MEM;
            end
            OP_LDI: begin
                e_next = E_PCREL9;
                w_next = W_MEM;
                m_next = 1'b1;
            end
            OP_STI: begin
                e_next = E_PCREL9;
                m_next = 1'b1;
            end
            OP_LEA: begin
                e_next = E_PCREL9;
                w_next = W_PC;
            end
            OP_LDR: begin
                e_next = E_BASE6;
                w_next = W_MEM;
            end
            OP_STR: e_next = E_BASE6;
            OP_JMP: e_next = E_BASE0;
            // 0100, 1000, 1101, 1111: unsupported, all controls stay zero
            default: ill_next = 1'b1;
        endcase
    end

    // Output registers: capture on enable, hold otherwise, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            IR          <= 16'h0000;
            npc_out     <= 16'h0000;
            E_Control   <= 6'b000000;
            W_Control   <= 2'b00;
            Mem_Control <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (enable_decode) begin
            IR          <= dout;
            npc_out     <= npc_in;
            E_Control   <= e_next;
            W_Control   <= w_next;
            Mem_Control <= m_next;
            illegal_op  <= ill_next;
        end
    end

endmodule

// File: tb/tb_lc3_decode.sv
// ----------------------------------------------------------------------------
// tb_lc3_decode
//
// Self-checking bench for lc3_decode: a table of directed vectors, an opcode
// sweep, randomized traffic checked against a table-based reference model,
// and hand-written sequences around the asynchronous reset.
// ----------------------------------------------------------------------------
module tb_lc3_decode;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        ill;
    } outs_t;

    typedef struct packed {
        logic        en;
        logic [15:0] d;
        logic [15:0] n;
        outs_t       exp;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        enable_decode;
    logic [15:0] dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        illegal_op;

    int compared;
    int mismatched;

    // Reference behaviour per opcode, written as lookup tables
    logic [5:0] e_tab [16];
    logic [1:0] w_tab [16];
    logic       m_tab [16];
    logic       ill_tab [16];

    outs_t held;
    vec_t  vecs [15];

    lc3_decode dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
        .IR            (IR),
        .npc_out       (npc_out),
        .E_Control     (E_Control),
        .W_Control     (W_Control),
        .Mem_Control   (Mem_Control),
        .illegal_op    (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs for a captured word, built from the opcode tables;
    // ADD/AND additionally take op2select from the immediate flag.
    function automatic outs_t model(input logic [15:0] d, input logic [15:0] n);
        outs_t r;
        int op;
        op    = int'(d[15:12]);
        r.ir  = d;
        r.npc = n;
        r.e   = e_tab[op];
        if ((op == 1 || op == 5) && d[5] == 1'b0)
            r.e = r.e + 6'd1;
        r.w   = w_tab[op];
        r.m   = m_tab[op];
        r.ill = ill_tab[op];
        return r;
    endfunction

    task automatic applyStimulus(input logic en, input logic [15:0] d, input logic [15:0] n);
        @(negedge clock);
        enable_decode = en;
        dout          = d;
        npc_in        = n;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = '{IR, npc_out, E_Control, W_Control, Mem_Control, illegal_op};
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got IR=%h npc=%h E=%b W=%b M=%b ill=%b, want IR=%h npc=%h E=%b W=%b M=%b ill=%b",
                     name, act.ir, act.npc, act.e, act.w, act.m, act.ill,
                     exp.ir, exp.npc, exp.e, exp.w, exp.m, exp.ill);
        end
    endtask

    initial begin
        outs_t zero;
        zero = '0;
        compared   = 0;
        mismatched = 0;

        for (int i = 0; i < 16; i++) begin
            e_tab[i] = 6'b000000; w_tab[i] = 2'b00; m_tab[i] = 1'b0; ill_tab[i] = 1'b0;
        end
        e_tab[4'b0001] = 6'b000000;
        e_tab[4'b0101] = 6'b010000;
        e_tab[4'b1001] = 6'b100000;
        e_tab[4'b0000] = 6'b000110;
        e_tab[4'b0011] = 6'b000110;
        e_tab[4'b0010] = 6'b000110; w_tab[4'b0010] = 2'b10;
        e_tab[4'b1010] = 6'b000110; w_tab[4'b1010] = 2'b10; m_tab[4'b1010] = 1'b1;
        e_tab[4'b1011] = 6'b000110; m_tab[4'b1011] = 1'b1;
        e_tab[4'b1110] = 6'b000110; w_tab[4'b1110] = 2'b01;
        e_tab[4'b0110] = 6'b001000; w_tab[4'b0110] = 2'b10;
        e_tab[4'b0111] = 6'b001000;
        e_tab[4'b1100] = 6'b001100;
        ill_tab[4'b0100] = 1'b1;
        ill_tab[4'b1000] = 1'b1;
        ill_tab[4'b1101] = 1'b1;
        ill_tab[4'b1111] = 1'b1;

        // Directed vectors with hand-derived expectations
        vecs[0]  = '{1'b1, 16'h1283, 16'h3001, '{16'h1283, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0}};
        vecs[1]  = '{1'b1, 16'h12A5, 16'h3002, '{16'h12A5, 16'h3002, 6'b000000, 2'b00, 1'b0, 1'b0}};
        vecs[2]  = '{1'b1, 16'hA010, 16'h3003, '{16'hA010, 16'h3003, 6'b000110, 2'b10, 1'b1, 1'b0}};
        vecs[3]  = '{1'b1, 16'h6943, 16'h3004, '{16'h6943, 16'h3004, 6'b001000, 2'b10, 1'b0, 1'b0}};
        vecs[4]  = '{1'b1, 16'hB010, 16'h3005, '{16'hB010, 16'h3005, 6'b000110, 2'b00, 1'b1, 1'b0}};
        vecs[5]  = '{1'b1, 16'hE1FF, 16'h3006, '{16'hE1FF, 16'h3006, 6'b000110, 2'b01, 1'b0, 1'b0}};
        vecs[6]  = '{1'b1, 16'hC1C0, 16'h3007, '{16'hC1C0, 16'h3007, 6'b001100, 2'b00, 1'b0, 1'b0}};
        for (int i = 7; i < 12; i++)
            vecs[i] = '{1'b0, 16'h5000, 16'h4000 + 16'(i), '{16'hC1C0, 16'h3007, 6'b001100, 2'b00, 1'b0, 1'b0}};
        vecs[12] = '{1'b1, 16'hF025, 16'h3005, '{16'hF025, 16'h3005, 6'b000000, 2'b00, 1'b0, 1'b1}};
        vecs[13] = '{1'b1, 16'h927F, 16'h3006, '{16'h927F, 16'h3006, 6'b100000, 2'b00, 1'b0, 1'b0}};
        vecs[14] = '{1'b1, 16'h0000, 16'hFFFF, '{16'h0000, 16'hFFFF, 6'b000110, 2'b00, 1'b0, 1'b0}};

        reset         = 1'b1;
        enable_decode = 1'b0;
        dout          = 16'h0000;
        npc_in        = 16'h0000;
        #1;
        checkOutput("reset_initial", zero);

        // Release reset together with enable: capture on the next edge
        @(negedge clock);
        reset         = 1'b0;
        enable_decode = 1'b1;
        dout          = 16'h1283;
        npc_in        = 16'h3001;
        @(posedge clock);
        #1;
        checkOutput("release_capture", model(16'h1283, 16'h3001));

        // Asynchronous reset between edges clears outputs immediately
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_midcycle", zero);
        @(posedge clock);
        #1;
        checkOutput("reset_held_edge1", zero);
        @(posedge clock);
        #1;
        checkOutput("reset_held_edge2", zero);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].en, vecs[i].d, vecs[i].n);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Sweep all 16 opcodes, both immediate-flag settings
        for (int op = 0; op < 16; op++) begin
            for (int b5 = 0; b5 < 2; b5++) begin
                logic [15:0] d;
                logic [15:0] n;
                d = {4'(op), 12'h0C3 | (b5 != 0 ? 12'h020 : 12'h000)};
                n = 16'h8000 + 16'(op * 2 + b5);
                applyStimulus(1'b1, d, n);
                checkOutput($sformatf("sweep_op%0d_b%0d", op, b5), model(d, n));
            end
        end

        // Randomized traffic with random enable gaps
        held = '{IR, npc_out, E_Control, W_Control, Mem_Control, illegal_op};
        held = model(dout, npc_in);
        for (int i = 0; i < 300; i++) begin
            logic        en;
            logic [15:0] d;
            logic [15:0] n;
            en = ($urandom_range(0, 3) != 0);
            d  = 16'($urandom);
            n  = 16'($urandom);
            applyStimulus(en, d, n);
            if (en)
                held = model(d, n);
            checkOutput($sformatf("rand%0d", i), held);
        end

        // Reset mid-stream discards the captured instruction, then recovery
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_midstream", zero);
        @(negedge clock);
        reset         = 1'b0;
        enable_decode = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("post_reset_hold", zero);
        applyStimulus(1'b1, 16'h5A3F, 16'h1234);
        checkOutput("post_reset_capture", model(16'h5A3F, 16'h1234));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lc3_decode.md
# lc3_decode

Decode pipeline stage of the LC-3 datapath, and the consumer of the decode-input interface (`dout`, `npc_in`, `enable_decode`) that Fetch/instruction memory drives. On each enabled clock edge it registers the fetched instruction and next-PC and produces the registered control bundles consumed by Execute, Writeback and the memory-access controller. When not enabled it holds all outputs, which stalls downstream stages.

## Interface
- No parameters; all widths fixed by the LC-3 ISA.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable_decode`  in  1  capture strobe, sampled at posedge.
- `dout`  in  16  instruction word from instruction memory.
- `npc_in`  in  16  PC+1 of the instruction on `dout`.
- `IR`  out  16  registered instruction.
- `npc_out`  out  16  registered `npc_in`.
- `E_Control`  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- `W_Control`  out  2  writeback source select.
- `Mem_Control`  out  1  indirect memory access flag.
- `illegal_op`  out  1  registered unsupported-opcode flag.

## Operation
- Opcode is `dout[15:12]`. Control is decoded from `dout` (not from `IR`) and registered together with it.
- alu_control: 00 add/pass, 01 AND, 10 NOT.
- pcselect1: 01 offset9, 10 offset6, 11 zero, 00 unused.
- pcselect2: 1 selects NPC base, 0 selects BaseR.
- op2select: 1 selects the register operand, 0 selects imm5.
- W_Control: 00 ALU, 01 PC-relative address (LEA), 10 memory data.
- E_Control / W_Control / Mem_Control per opcode:
  - ADD 0001: E = 000001 if `dout[5]`=0, else 000000; W 00; M 0.
  - AND 0101: E = 010001 if `dout[5]`=0, else 010000; W 00; M 0.
  - NOT 1001: E 100000; W 00; M 0.
  - BR 0000, ST 0011: E 000110; W 00; M 0.
  - LD 0010: E 000110; W 10; M 0.
  - LDI 1010: E 000110; W 10; M 1.
  - STI 1011: E 000110; W 00; M 1.
  - LEA 1110: E 000110; W 01; M 0.
  - LDR 0110: E 001000; W 10; M 0.
  - STR 0111: E 001000; W 00; M 0.
  - JMP 1100: E 001100; W 00; M 0.
- Illegal opcodes 0100, 1000, 1101, 1111:
  - E, W and M are all 0; `illegal_op`=1.
  - `IR` and `npc_out` are still captured.
- `illegal_op`=0 for every legal opcode.
- No internal state beyond the output registers. No FSM: the block has two modes, capture (enable=1) and hold (enable=0).

## Timing
- Reset:
  - While `reset`=1, every output is 0 (`IR`=0, `npc_out`=0, `E_Control`=0, `W_Control`=0, `Mem_Control`=0, `illegal_op`=0).
  - Assertion clears the outputs immediately, independent of `clock`.
  - Reset asserted mid-stream discards the captured instruction.
- First capture is the first posedge with `reset`=0 and `enable_decode`=1.
- Latency: 1 cycle. Inputs sampled at posedge N appear on all outputs after posedge N; every output updates on that same edge.
- Hold: at any posedge with `enable_decode`=0, all outputs keep their value, whatever `dout`/`npc_in` are doing.
- Back-to-back: `enable_decode` high for K consecutive edges captures K instructions, one per cycle, with no bubbles.
- Release: `reset` deasserting in the same cycle as `enable_decode`=1 captures on the next posedge.
- Arithmetic: none. `npc_out` is a straight 16-bit copy, so there is no wrap handling (0xFFFF passes unchanged).

## Test plan
- Reset: drive `dout`=0x1283 and enable=1, then assert reset asynchronously between edges -> all outputs are 0 before the next posedge and stay 0 while reset is held.
- ADD register then immediate, back-to-back:
  - 0x1283, npc 0x3001 -> IR 0x1283, npc_out 0x3001, E 000001, W 00, M 0.
  - next cycle 0x12A5 -> E 000000.
- Memory forms:
  - LDI 0xA010 -> E 000110, W 10, M 1.
  - LDR 0x6943 -> E 001000, W 10, M 0.
  - STI 0xB010 -> W 00, M 1.
  - LEA 0xE1FF -> W 01.
- Hold: capture JMP 0xC1C0 (E 001100), then enable=0 for 5 cycles while `dout`=0x5000 and `npc_in` changes -> outputs stay at the JMP values.
- Illegal: 0xF025 with npc 0x3005 -> IR 0xF025, npc_out 0x3005, E/W/M 0, `illegal_op` 1; next legal NOT 0x927F -> `illegal_op` 0, E 100000.
- Boundaries: `npc_in`=0xFFFF -> `npc_out` 0xFFFF; all 16 opcodes swept against the table above.
